// File: rtl/kmap_pkg.sv
// Shared definitions for the programmable truth-table engine: cfg_val encoding,
// sweep FSM states and the ones_cnt slice-offset helper.
package kmap_pkg;

  // cfg_val encoding: 00 = 0, 01 = 1, 1x = don't-care
  localparam logic [1:0]  CV_ZERO   = 2'b00;
  localparam logic [1:0]  CV_ONE    = 2'b01;
  localparam int unsigned CV_DC_BIT = 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SWEEP = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  // Bit offset of function k's on-set counter inside the packed ones_cnt bus
  function automatic int unsigned cnt_off(input int unsigned k, input int unsigned n_in);
    return k * (n_in + 1);
  endfunction

endpackage

// File: rtl/kmap_fn_table.sv
// One function's truth table: a value bit and a don't-care bit per minterm.
// Ports:
//   clk, rst           clock, async active-high reset (clears table)
//   we, waddr          write strobe and minterm address
//   wval, wdc          value and don't-care bit to store
//   raddr_a            eval read address  -> rval_a_c, rdc_a_c (combinational)
//   raddr_b            sweep read address -> rval_b_c, rdc_b_c (combinational)
module kmap_fn_table #(
  parameter int unsigned N_IN = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [N_IN-1:0] waddr,
  input  logic            wval,
  input  logic            wdc,
  input  logic [N_IN-1:0] raddr_a,
  input  logic [N_IN-1:0] raddr_b,
  output logic            rval_a_c,
  output logic            rdc_a_c,
  output logic            rval_b_c,
  output logic            rdc_b_c
);

  localparam int unsigned DEPTH = 1 << N_IN;

  logic [DEPTH-1:0] val_q, val_d;
  logic [DEPTH-1:0] dc_q,  dc_d;

  // Single write port
  always_comb begin
    val_d = val_q;
    dc_d  = dc_q;
    if (we) begin
      val_d[waddr] = wval;
      dc_d[waddr]  = wdc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      val_q <= '0;
      dc_q  <= '0;
    end else begin
      val_q <= val_d;
      dc_q  <= dc_d;
    end
  end

  // Reads see pre-write contents, giving read-before-write on a same-cycle collision
  assign rval_a_c = val_q[raddr_a];
  assign rdc_a_c  = dc_q[raddr_a];
  assign rval_b_c = val_q[raddr_b];
  assign rdc_b_c  = dc_q[raddr_b];

endmodule

// File: rtl/kmap_lut_engine.sv
// Programmable truth-table evaluator: N_FN functions of N_IN inputs with
// 0/1/don't-care minterms, single-cycle registered evaluation and an
// exhaustive sweep that counts each function's on-set.
// Ports:
//   clk, rst                         clock, async active-high reset
//   cfg_we/cfg_fn/cfg_addr/cfg_val   table write (IDLE only; cfg_fn >= N_FN ignored)
//   dc_fill                          per-function value used for don't-care minterms
//   in_valid/in_ready/in_x           evaluation request handshake and input vector
//   out_valid/out_f/out_dc           evaluation result, one cycle after accept
//   sweep_start/sweep_busy/sweep_done  sweep control and status
//   ones_cnt                         per-function on-set counts, N_IN+1 bits each
module kmap_lut_engine
  import kmap_pkg::*;
#(
  parameter  int unsigned N_IN = 4,
  parameter  int unsigned N_FN = 3,
  localparam int unsigned FNW  = (N_FN > 1) ? $clog2(N_FN) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_we,
  input  logic [FNW-1:0]           cfg_fn,
  input  logic [N_IN-1:0]          cfg_addr,
  input  logic [1:0]               cfg_val,
  input  logic [N_FN-1:0]          dc_fill,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N_IN-1:0]          in_x,
  output logic                     out_valid,
  output logic [N_FN-1:0]          out_f,
  output logic [N_FN-1:0]          out_dc,
  input  logic                     sweep_start,
  output logic                     sweep_busy,
  output logic                     sweep_done,
  output logic [N_FN*(N_IN+1)-1:0] ones_cnt
);

  localparam int unsigned CW    = N_IN + 1;
  localparam int unsigned DEPTH = 1 << N_IN;
  localparam logic [N_IN-1:0] LAST = N_IN'(DEPTH - 1);

  state_e                   state_q, state_d;
  logic [N_IN-1:0]          cnt_q, cnt_d;
  logic                     in_ready_q, in_ready_d;
  logic                     out_valid_q, out_valid_d;
  logic [N_FN-1:0]          out_f_q, out_f_d;
  logic [N_FN-1:0]          out_dc_q, out_dc_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic [N_FN*CW-1:0]       ones_q, ones_d;

  logic                     wr_en;
  logic                     accept;
  logic                     wval;
  logic                     wdc;
  logic [N_FN-1:0]          tbl_we;
  logic [N_FN-1:0]          eval_val, eval_dc, eval_fill;
  logic [N_FN-1:0]          sw_val, sw_dc, sw_fill;

  assign wr_en  = cfg_we && (state_q == S_IDLE);
  assign accept = in_valid && in_ready_q;
  assign wdc    = cfg_val[CV_DC_BIT];
  assign wval   = (cfg_val == CV_ONE) && (cfg_val != CV_ZERO);

  // Per-function tables; an out-of-range cfg_fn matches no instance and is dropped
  for (genvar k = 0; k < N_FN; k++) begin : g_fn
    assign tbl_we[k] = wr_en && (cfg_fn == FNW'(k));

    kmap_fn_table #(.N_IN(N_IN)) u_tbl (
      .clk      (clk),
      .rst      (rst),
      .we       (tbl_we[k]),
      .waddr    (cfg_addr),
      .wval     (wval),
      .wdc      (wdc),
      .raddr_a  (in_x),
      .raddr_b  (cnt_q),
      .rval_a_c (eval_val[k]),
      .rdc_a_c  (eval_dc[k]),
      .rval_b_c (sw_val[k]),
      .rdc_b_c  (sw_dc[k])
    );
  end

  // Don't-care minterms take the live dc_fill bit
  assign eval_fill = (eval_dc & dc_fill) | (~eval_dc & eval_val);
  assign sw_fill   = (sw_dc & dc_fill)   | (~sw_dc & sw_val);

  // Next-state, sweep accumulation and evaluation capture
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ones_d      = ones_q;
    out_valid_d = accept;
    out_f_d     = out_f_q;
    out_dc_d    = out_dc_q;

    if (accept) begin
      out_f_d  = eval_fill;
      out_dc_d = eval_dc;
    end

    unique case (state_q)
      S_IDLE: begin
        if (sweep_start) begin
          state_d = S_SWEEP;
          cnt_d   = '0;
          ones_d  = '0;
        end
      end
      S_SWEEP: begin
        for (int unsigned k = 0; k < N_FN; k++) begin
          ones_d[cnt_off(k, N_IN) +: CW] = ones_q[cnt_off(k, N_IN) +: CW] + CW'(sw_fill[k]);
        end
        cnt_d = cnt_q + N_IN'(1);
        if (cnt_q == LAST) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Status outputs are registered copies of the next state
    in_ready_d = (state_d == S_IDLE);
    busy_d     = (state_d != S_IDLE);
    done_d     = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_f_q     <= '0;
      out_dc_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ones_q      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_f_q     <= out_f_d;
      out_dc_q    <= out_dc_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      ones_q      <= ones_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_f      = out_f_q;
  assign out_dc     = out_dc_q;
  assign sweep_busy = busy_q;
  assign sweep_done = done_q;
  assign ones_cnt   = ones_q;

endmodule

// File: tb/tb_kmap_lut_engine.sv
// Randomized self-checking bench for kmap_lut_engine against a truth-table model.
module tb_kmap_lut_engine;

  localparam int unsigned N_IN  = 4;
  localparam int unsigned N_FN  = 3;
  localparam int unsigned FNW   = 2;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned CW    = 5;
  localparam int          IDLE_POS = -1;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  cfg_we;
  logic [FNW-1:0]        cfg_fn;
  logic [N_IN-1:0]       cfg_addr;
  logic [1:0]            cfg_val;
  logic [N_FN-1:0]       dc_fill;
  logic                  in_valid;
  logic                  in_ready;
  logic [N_IN-1:0]       in_x;
  logic                  out_valid;
  logic [N_FN-1:0]       out_f;
  logic [N_FN-1:0]       out_dc;
  logic                  sweep_start;
  logic                  sweep_busy;
  logic                  sweep_done;
  logic [N_FN*CW-1:0]    ones_cnt;

  always #5 clk = ~clk;

  kmap_lut_engine #(.N_IN(N_IN), .N_FN(N_FN)) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_we      (cfg_we),
    .cfg_fn      (cfg_fn),
    .cfg_addr    (cfg_addr),
    .cfg_val     (cfg_val),
    .dc_fill     (dc_fill),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_x        (in_x),
    .out_valid   (out_valid),
    .out_f       (out_f),
    .out_dc      (out_dc),
    .sweep_start (sweep_start),
    .sweep_busy  (sweep_busy),
    .sweep_done  (sweep_done),
    .ones_cnt    (ones_cnt)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: truth tables, sweep position (-1 idle, 0..15 minterm being added, 16 done)
  bit              mval [N_FN][DEPTH];
  bit              mdc  [N_FN][DEPTH];
  int              m_pos;
  bit              m_ready;
  int              m_ones [N_FN];
  logic [N_FN-1:0] last_f;
  logic [N_FN-1:0] last_dc;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit filled(input int k, input int m, input logic [N_FN-1:0] fill);
    return mdc[k][m] ? fill[k] : mval[k][m];
  endfunction

  function automatic logic [31:0] exp_ones();
    logic [31:0] v;
    v = '0;
    for (int k = 0; k < N_FN; k++) v = v | (32'(m_ones[k]) << (k * CW));
    return v;
  endfunction

  task automatic idle_inputs();
    cfg_we = 0; cfg_fn = '0; cfg_addr = '0; cfg_val = '0;
    in_valid = 0; in_x = '0; sweep_start = 0;
  endtask

  task automatic model_clear();
    for (int k = 0; k < N_FN; k++) begin
      m_ones[k] = 0;
      for (int m = 0; m < DEPTH; m++) begin mval[k][m] = 0; mdc[k][m] = 0; end
    end
    m_pos = IDLE_POS; m_ready = 0; last_f = '0; last_dc = '0;
  endtask

  // One clock with the currently driven inputs; model advances, then all outputs are checked
  task automatic step();
    bit              acc, wr;
    logic [N_FN-1:0] ef, ed;
    acc = in_valid && m_ready;
    wr  = cfg_we && (m_pos == IDLE_POS) && (int'(cfg_fn) < N_FN);
    ef = last_f; ed = last_dc;
    if (acc) begin
      for (int k = 0; k < N_FN; k++) begin
        ef[k] = filled(k, int'(in_x), dc_fill);
        ed[k] = mdc[k][in_x];
      end
    end
    if (m_pos == IDLE_POS) begin
      if (sweep_start) begin
        m_pos = 0;
        for (int k = 0; k < N_FN; k++) m_ones[k] = 0;
      end
    end else if (m_pos < DEPTH) begin
      for (int k = 0; k < N_FN; k++) m_ones[k] += int'(filled(k, m_pos, dc_fill));
      m_pos++;
    end else begin
      m_pos = IDLE_POS;
    end
    if (wr) begin
      mdc[cfg_fn][cfg_addr]  = cfg_val[1];
      mval[cfg_fn][cfg_addr] = (cfg_val == 2'b01);
    end
    m_ready = (m_pos == IDLE_POS);
    last_f = ef; last_dc = ed;
    @(posedge clk); #1;
    check_eq("out_valid",  32'(out_valid),  32'(acc));
    check_eq("out_f",      32'(out_f),      32'(ef));
    check_eq("out_dc",     32'(out_dc),     32'(ed));
    check_eq("in_ready",   32'(in_ready),   32'(m_ready));
    check_eq("sweep_busy", 32'(sweep_busy), 32'(m_pos != IDLE_POS));
    check_eq("sweep_done", 32'(sweep_done), 32'(m_pos == DEPTH));
    check_eq("ones_cnt",   32'(ones_cnt),   exp_ones());
  endtask

  task automatic do_reset();
    rst = 1; #1;
    check_eq("rst_out_valid",  32'(out_valid),  32'd0);
    check_eq("rst_out_f",      32'(out_f),      32'd0);
    check_eq("rst_out_dc",     32'(out_dc),     32'd0);
    check_eq("rst_sweep_busy", 32'(sweep_busy), 32'd0);
    check_eq("rst_sweep_done", 32'(sweep_done), 32'd0);
    check_eq("rst_ones_cnt",   32'(ones_cnt),   32'd0);
    check_eq("rst_in_ready",   32'(in_ready),   32'd0);
    model_clear();
    idle_inputs();
    @(posedge clk); #1;
    rst = 0;
  endtask

  task automatic cfg_write(input int fn, input int addr, input logic [1:0] v);
    cfg_we = 1; cfg_fn = FNW'(fn); cfg_addr = N_IN'(addr); cfg_val = v;
    step();
    cfg_we = 0;
  endtask

  // Start a sweep and run it to the done pulse; counts busy cycles before done
  task automatic run_sweep(input logic [N_FN-1:0] fill, output int busy_cyc, output bit saw_done);
    dc_fill = fill;
    sweep_start = 1;
    step();
    sweep_start = 0;
    busy_cyc = 0; saw_done = 0;
    for (int i = 0; i < 40; i++) begin
      if (sweep_done) begin saw_done = 1; break; end
      if (sweep_busy) busy_cyc++;
      step();
    end
    if (saw_done) step();
  endtask

  logic [DEPTH-1:0] f1_on, f2_on, f2_dc;
  int               bc;
  bit               sd;
  logic [3:0]       mv;

  initial begin
    rst = 1;
    idle_inputs();
    dc_fill = '0;
    f1_on = 16'hEDE0;
    f2_on = 16'hD1CC;
    f2_dc = 16'h2222;
    #2;
    do_reset();
    step();

    // Empty-table evaluation
    in_valid = 1; in_x = 4'b0101;
    step();
    in_valid = 0;
    check_eq("empty_eval_valid", 32'(out_valid), 32'd1);
    check_eq("empty_eval_f",     32'(out_f),     32'd0);
    check_eq("empty_eval_dc",    32'(out_dc),    32'd0);
    step();
    check_eq("valid_pulse", 32'(out_valid), 32'd0);

    // Load parity, F1 and F2 (with don't-cares written as 1x)
    for (int m = 0; m < DEPTH; m++) begin
      mv = 4'(m);
      cfg_write(0, m, {1'b0, ^mv});
      cfg_write(1, m, {1'b0, f1_on[m]});
      if (f2_dc[m]) cfg_write(2, m, {1'b1, 1'($urandom)});
      else          cfg_write(2, m, {1'b0, f2_on[m]});
    end
    cfg_write(3, 0, 2'b01);

    run_sweep(3'b000, bc, sd);
    check_eq("sweep1_busy_cycles", 32'(bc), 32'd16);
    check_eq("sweep1_done_seen",   32'(sd), 32'd1);
    check_eq("sweep1_f0", 32'(ones_cnt[0*CW +: CW]), 32'd8);
    check_eq("sweep1_f1", 32'(ones_cnt[1*CW +: CW]), 32'd9);
    check_eq("sweep1_f2", 32'(ones_cnt[2*CW +: CW]), 32'd8);

    run_sweep(3'b100, bc, sd);
    check_eq("sweep2_done_seen", 32'(sd), 32'd1);
    check_eq("sweep2_f0", 32'(ones_cnt[0*CW +: CW]), 32'd8);
    check_eq("sweep2_f1", 32'(ones_cnt[1*CW +: CW]), 32'd9);
    check_eq("sweep2_f2", 32'(ones_cnt[2*CW +: CW]), 32'd12);

    in_valid = 1; in_x = 4'b1101;
    step();
    in_valid = 0;
    check_eq("eval13_f2", 32'(out_f[2]), 32'd1);
    check_eq("eval13_dc", 32'(out_dc),   32'b100);

    // All vectors back-to-back, with a colliding write to F1[5]
    in_valid = 1;
    for (int x = 0; x < DEPTH; x++) begin
      in_x = 4'(x);
      if (x == 5) begin cfg_we = 1; cfg_fn = 2'd1; cfg_addr = 4'd5; cfg_val = 2'b00; end
      step();
      cfg_we = 0;
      if (x == 5) check_eq("rbw_old_f1", 32'(out_f[1]), 32'd1);
    end
    in_x = 4'd5;
    step();
    in_valid = 0;
    check_eq("rbw_new_f1", 32'(out_f[1]), 32'd0);

    // Requests during a sweep are ignored
    dc_fill = 3'b000;
    sweep_start = 1;
    step();
    step();
    sweep_start = 1; cfg_we = 1; cfg_fn = 2'd0; cfg_addr = 4'd3; cfg_val = 2'b01; in_valid = 1; in_x = 4'd3;
    for (int i = 0; i < 4; i++) begin
      step();
      check_eq("busy_in_ready", 32'(in_ready), 32'd0);
    end
    idle_inputs();
    for (int i = 0; i < 40 && sweep_busy; i++) step();
    check_eq("busy_end_idle", 32'(sweep_busy), 32'd0);
    in_valid = 1; in_x = 4'd3;
    step();
    in_valid = 0;
    check_eq("busy_write_ignored_f0", 32'(out_f[0]), 32'd0);

    // Reset in the middle of a sweep
    sweep_start = 1;
    step();
    sweep_start = 0;
    for (int i = 0; i < 7; i++) step();
    do_reset();
    step();
    run_sweep(3'b111, bc, sd);
    check_eq("post_rst_done_seen", 32'(sd),       32'd1);
    check_eq("post_rst_counts",    32'(ones_cnt), 32'd0);

    // Random traffic: writes (incl. out-of-range fn), evals, sweeps, live dc_fill changes
    for (int i = 0; i < 600; i++) begin
      cfg_we      = ($urandom_range(0, 9) < 3);
      cfg_fn      = FNW'($urandom_range(0, 3));
      cfg_addr    = N_IN'($urandom);
      cfg_val     = 2'($urandom);
      in_valid    = ($urandom_range(0, 1) == 1);
      in_x        = N_IN'($urandom);
      dc_fill     = N_FN'($urandom);
      sweep_start = ($urandom_range(0, 29) == 0);
      step();
    end
    idle_inputs();
    for (int i = 0; i < 20; i++) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
